load_store_unit: RTL and testbench

- CPU-side initiator for the byte-addressed memory controller.
- Accepts one load or store request from the execute stage and checks alignment, range and funct3.
- Drives the memory enable/addr/we/instr_mode handshake, waits for op_r, then sign- or zero-extends load data.
- Returns a single-cycle response to writeback. One transaction is in flight at a time.

---
 rtl/cpu_mem_pkg.sv | 36 +++
 rtl/load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared funct3, memory mode, fault code and LSU state definitions
package cpu_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] MODE_W = 2'b00;
  localparam logic [1:0] MODE_B = 2'b01;
  localparam logic [1:0] MODE_H = 2'b10;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP,
    LSU_FAULT
  } lsu_state_e;

  // Access size field of funct3 (bits [1:0]) to the memory's instr_mode encoding.
  function automatic logic [1:0] size_to_mode(input logic [1:0] size);
    case (size)
      2'b00:   return MODE_B;
      2'b01:   return MODE_H;
      default: return MODE_W;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of raw memory data according to load funct3
module load_extend
  import cpu_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // Upper bytes are always masked here; the memory may return anything above the access size.
  always_comb begin
    result = raw;
    case (funct3)
      F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
      F3_LBU:  result = {24'h00_0000, raw[7:0]};
      F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
      F3_LHU:  result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for the byte-addressed memory controller
module load_store_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_fault_code,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_instr_mode,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_op_r
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_next;
  logic [2:0]  lat_funct3;
  logic        lat_we;
  logic        f3_legal;
  logic        access_fault;
  logic        misaligned;
  logic [31:0] ext_data;

  assign req_ready = (state == LSU_IDLE);
  assign cnt_next  = wait_cnt + 8'd1;

  always_comb begin
    f3_legal     = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    access_fault = !f3_legal || (req_we && req_funct3[2]) || ((req_addr >> ADDR_W) != 32'd0);
    misaligned   = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                   ((req_funct3[1:0] == 2'b01) && req_addr[0]);
  end

  load_extend u_load_extend (
    .funct3 (lat_funct3),
    .raw    (mem_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LSU_IDLE;
      wait_cnt       <= 8'd0;
      lat_funct3     <= 3'b000;
      lat_we         <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 32'd0;
      rsp_fault      <= 1'b0;
      rsp_fault_code <= FAULT_NONE;
      mem_enable     <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= 32'd0;
      mem_instr_mode <= MODE_W;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            lat_funct3 <= req_funct3;
            lat_we     <= req_we;
            if (access_fault) begin
              state          <= LSU_FAULT;
              rsp_valid      <= 1'b1;
              rsp_fault      <= 1'b1;
              rsp_fault_code <= FAULT_ACCESS;
            end else if (misaligned) begin
              state          <= LSU_FAULT;
              rsp_valid      <= 1'b1;
              rsp_fault      <= 1'b1;
              rsp_fault_code <= FAULT_MISALIGN;
            end else begin
              // Memory-side fields stay put until the next good request, covering the whole WAIT.
              state          <= LSU_ISSUE;
              mem_enable     <= 1'b1;
              mem_addr       <= req_addr[ADDR_W-1:0];
              mem_we         <= req_we;
              mem_wdata      <= req_wdata;
              mem_instr_mode <= size_to_mode(req_funct3[1:0]);
            end
          end
        end
        LSU_ISSUE: begin
          mem_enable <= 1'b0;
          wait_cnt   <= 8'd0;
          state      <= LSU_WAIT;
        end
        LSU_WAIT: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (mem_op_r) begin
            state          <= LSU_RESP;
            rsp_valid      <= 1'b1;
            rsp_fault      <= 1'b0;
            rsp_fault_code <= FAULT_NONE;
            rsp_rdata      <= lat_we ? 32'd0 : ext_data;
          end else begin
            wait_cnt <= cnt_next;
            if (cnt_next == TIMEOUT_LIMIT) begin
              state          <= LSU_FAULT;
              rsp_valid      <= 1'b1;
              rsp_fault      <= 1'b1;
              rsp_fault_code <= FAULT_TIMEOUT;
            end
          end
        end
        LSU_RESP, LSU_FAULT: begin
          state          <= LSU_IDLE;
          rsp_valid      <= 1'b0;
          rsp_fault      <= 1'b0;
          rsp_fault_code <= FAULT_NONE;
          rsp_rdata      <= 32'd0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural memory
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_fault_code;
  logic        mem_enable;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_instr_mode;
  logic [31:0] mem_rdata;
  logic        mem_op_r;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 5;
  logic mem_busy;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .rsp_fault_code (rsp_fault_code),
    .mem_enable     (mem_enable),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_instr_mode (mem_instr_mode),
    .mem_rdata      (mem_rdata),
    .mem_op_r       (mem_op_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: samples the start, finishes mem_lat cycles later; unused upper read bytes are garbage.
  initial begin
    logic [7:0]  a;
    logic        w;
    logic [31:0] wd;
    logic [1:0]  md;
    logic [31:0] rd;
    mem_op_r  = 1'b0;
    mem_rdata = 32'hdead_beef;
    mem_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_enable === 1'b1) begin
        a = mem_addr[7:0]; w = mem_we; wd = mem_wdata; md = mem_instr_mode;
        mem_busy = 1'b1;
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        rd = $urandom;
        if (md == 2'b01) begin
          if (w) mem[a] = wd[7:0];
          rd[7:0] = mem[a];
        end else if (md == 2'b10) begin
          if (w) begin mem[a] = wd[7:0]; mem[8'(a + 1)] = wd[15:8]; end
          rd[15:0] = {mem[8'(a + 1)], mem[a]};
        end else begin
          if (w) for (int i = 0; i < 4; i++) mem[8'(a + i)] = wd[8*i +: 8];
          rd = {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
        end
        mem_op_r  = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_op_r  = 1'b0;
        mem_rdata = $urandom;
        mem_busy  = 1'b0;
      end
    end
  end

  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [1:0] code, output logic [31:0] rd);
    int size;
    logic [31:0] v;
    logic [7:0] a;
    rd = 32'd0;
    a = addr[7:0];
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4) || addr > 32'h00FF_FFFF) code = 2'b10;
    else if (addr % size != 0) code = 2'b01;
    else begin
      code = 2'b00;
      if (we) begin
        for (int i = 0; i < size; i++) shadow[8'(a + i)] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = shadow[8'(a + i)];
        if (size == 4 || f3[2]) rd = v;
        else if (size == 1) rd = v[7] ? (v | 32'hFFFF_FF00) : v;
        else rd = v[15] ? (v | 32'hFFFF_0000) : v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic fault, output logic [1:0] code,
                        output int lat, output int ens);
    int k;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_wait ready=%0b required=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    lat = 0; ens = 0;
    while (!rsp_valid && lat < 60) begin
      if (mem_enable) ens++;
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata; fault = rsp_fault; code = rsp_fault_code;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rsp_one_shot valid=%0b ready=%0b required valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic check_rsp(input string name, input logic [31:0] rd, input logic fault, input logic [1:0] code,
                           input int lat, input int ens, input logic [31:0] exp_rd, input logic [1:0] exp_code,
                           input int exp_lat, input int exp_ens);
    checks++;
    if (rd !== exp_rd || fault !== (exp_code != 2'b00) || code !== exp_code || lat !== exp_lat || ens !== exp_ens) begin
      failures++;
      $display("FAIL %s got rdata=%h fault=%0b code=%0d lat=%0d en=%0d required rdata=%h code=%0d lat=%0d en=%0d",
               name, rd, fault, code, lat, ens, exp_rd, exp_code, exp_lat, exp_ens);
    end
  endtask

  task automatic watch_quiet(input string name);
    int seen;
    int n;
    seen = 0; n = 0;
    while ((mem_busy || n < 4) && n < 400) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      n++;
    end
    checks++;
    if (seen !== 0 || mem_busy) begin
      failures++;
      $display("FAIL %s rsp_valid_count=%0d mem_busy=%0b required 0 and 0", name, seen, mem_busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_fault_code !== 2'b00 ||
        rsp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL %s_rsp ready=%0b valid=%0b fault=%0b code=%0d rdata=%h required 1 0 0 0 00000000",
               name, req_ready, rsp_valid, rsp_fault, rsp_fault_code, rsp_rdata);
    end
    checks++;
    if (mem_enable !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 24'd0 || mem_wdata !== 32'd0 ||
        mem_instr_mode !== 2'b00) begin
      failures++;
      $display("FAIL %s_mem en=%0b we=%0b addr=%h wdata=%h mode=%0d required all zero",
               name, mem_enable, mem_we, mem_addr, mem_wdata, mem_instr_mode);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("lw16", rd, f, c, lat, ens, 32'haabbccdd, 2'b00, 6, 1);
    do_req(1'b0, 3'b000, 32'd19, 32'd0, rd, f, c, lat, ens);
    check_rsp("lb19", rd, f, c, lat, ens, 32'hffffffaa, 2'b00, 6, 1);
    do_req(1'b0, 3'b100, 32'd19, 32'd0, rd, f, c, lat, ens);
    check_rsp("lbu19", rd, f, c, lat, ens, 32'h000000aa, 2'b00, 6, 1);
    do_req(1'b0, 3'b001, 32'd18, 32'd0, rd, f, c, lat, ens);
    check_rsp("lh18", rd, f, c, lat, ens, 32'hffffaabb, 2'b00, 6, 1);
    do_req(1'b0, 3'b101, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("lhu16", rd, f, c, lat, ens, 32'h0000ccdd, 2'b00, 6, 1);
  endtask

  task automatic test_stores();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    do_req(1'b1, 3'b010, 32'd8, 32'h11223344, rd, f, c, lat, ens);
    check_rsp("sw8", rd, f, c, lat, ens, 32'd0, 2'b00, 6, 1);
    do_req(1'b1, 3'b001, 32'd8, 32'h00005566, rd, f, c, lat, ens);
    check_rsp("sh8", rd, f, c, lat, ens, 32'd0, 2'b00, 6, 1);
    do_req(1'b1, 3'b000, 32'd11, 32'h00000077, rd, f, c, lat, ens);
    check_rsp("sb11", rd, f, c, lat, ens, 32'd0, 2'b00, 6, 1);
    do_req(1'b0, 3'b010, 32'd8, 32'd0, rd, f, c, lat, ens);
    check_rsp("lw8_after_stores", rd, f, c, lat, ens, 32'h77225566, 2'b00, 6, 1);
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    do_req(1'b0, 3'b010, 32'd2, 32'd0, rd, f, c, lat, ens);
    check_rsp("lw_misaligned", rd, f, c, lat, ens, 32'd0, 2'b01, 0, 0);
    do_req(1'b0, 3'b001, 32'd17, 32'd0, rd, f, c, lat, ens);
    check_rsp("lh_misaligned", rd, f, c, lat, ens, 32'd0, 2'b01, 0, 0);
    do_req(1'b0, 3'b011, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("funct3_011", rd, f, c, lat, ens, 32'd0, 2'b10, 0, 0);
    do_req(1'b1, 3'b100, 32'd16, 32'h12345678, rd, f, c, lat, ens);
    check_rsp("store_f3_100", rd, f, c, lat, ens, 32'd0, 2'b10, 0, 0);
    do_req(1'b0, 3'b010, 32'h0100_0000, 32'd0, rd, f, c, lat, ens);
    check_rsp("out_of_range", rd, f, c, lat, ens, 32'd0, 2'b10, 0, 0);
    do_req(1'b0, 3'b010, 32'h00FF_FFFC, 32'd0, rd, f, c, lat, ens);
    check_rsp("top_of_range", rd, f, c, lat, ens,
              {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]}, 2'b00, 6, 1);
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    mem_lat = 200;
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("timeout", rd, f, c, lat, ens, 32'd0, 2'b11, 16, 1);
    watch_quiet("late_op_r_in_idle");
    mem_lat = 15;
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("completion_at_limit", rd, f, c, lat, ens, 32'haabbccdd, 2'b00, 16, 1);
    mem_lat = 16;
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("one_past_limit", rd, f, c, lat, ens, 32'd0, 2'b11, 16, 1);
    watch_quiet("op_r_after_timeout");
    mem_lat = 5;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'd18; req_wdata = 32'd0;
    @(negedge clk);
    req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("op_r_after_reset");
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, f, c, lat, ens);
    check_rsp("lw_after_reset", rd, f, c, lat, ens, 32'haabbccdd, 2'b00, 6, 1);
  endtask

  task automatic test_random();
    logic [31:0] rd; logic f; logic [1:0] c; int lat; int ens;
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    logic [1:0] exp_code; logic [31:0] exp_rd;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = (32'($urandom_range(1, 255)) << 24) | 32'($urandom_range(0, 255));
      else addr = 32'($urandom_range(0, 255));
      wd = $urandom;
      ref_model(we, f3, addr, wd, exp_code, exp_rd);
      do_req(we, f3, addr, wd, rd, f, c, lat, ens);
      check_rsp("random", rd, f, c, lat, ens, exp_rd, exp_code,
                (exp_code == 2'b00) ? 6 : 0, (exp_code == 2'b00) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[16] = 8'hdd; mem[17] = 8'hcc; mem[18] = 8'hbb; mem[19] = 8'haa;
    #3;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
